// File: rtl/rsa_pkg.sv
// Shared constants and types for the RSA modular-reduction datapath.
package rsa_pkg;

  localparam int RSA_DIVIDEND_W = 256;
  localparam int RSA_MOD_W      = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mod_state_t;

  localparam logic [RSA_MOD_W-1:0] N_TEST = 128'd108992493821499052737214080527692688753;

endpackage

// File: rtl/mod_reduce_step.sv
// One restoring shift-subtract step: shift a dividend bit into r, subtract B when it fits.
module mod_reduce_step
  import rsa_pkg::*;
#(
  parameter int MOD_W = RSA_MOD_W
) (
  input  logic [MOD_W-1:0] r_in,
  input  logic             bit_in,
  input  logic [MOD_W-1:0] b,
  output logic [MOD_W-1:0] r_next,
  output logic             sub
);

  logic [MOD_W:0]   r_shift;
  logic [MOD_W-1:0] diff;

  // r_in < b, so r_shift < 2b; when it is subtracted the result is < b and the
  // low MOD_W bits of the difference are exact.
  always_comb begin
    r_shift = {r_in, bit_in};
    sub     = (r_shift >= {1'b0, b});
    diff    = r_shift[MOD_W-1:0] - b;
    r_next  = sub ? diff : r_shift[MOD_W-1:0];
  end

endmodule

// File: rtl/mod_reduce_seq.sv
// Sequential A mod B reducer, one dividend bit per clock, fixed latency of DIVIDEND_W+1 cycles.
module mod_reduce_seq
  import rsa_pkg::*;
#(
  parameter int DIVIDEND_W = RSA_DIVIDEND_W,
  parameter int MOD_W      = RSA_MOD_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIVIDEND_W-1:0] A,
  input  logic [MOD_W-1:0]      B,
  input  logic                  dividend_valid,
  input  logic                  divisor_valid,
  output logic                  remainder_valid,
  output logic [MOD_W-1:0]      remainder,
  output logic                  div_by_zero,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DIVIDEND_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIVIDEND_W - 1);

  mod_state_t            state_q, state_d;
  logic [DIVIDEND_W-1:0] a_q, a_d;
  logic [MOD_W-1:0]      b_q, b_d;
  logic [MOD_W-1:0]      r_q, r_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [MOD_W-1:0]      rem_q, rem_d;
  logic                  rv_q, rv_d;
  logic                  dbz_q, dbz_d;

  logic                  req;
  logic [MOD_W-1:0]      step_r;
  logic                  step_sub;

  assign req = dividend_valid & divisor_valid;

  mod_reduce_step #(
    .MOD_W (MOD_W)
  ) u_step (
    .r_in   (r_q),
    .bit_in (a_q[DIVIDEND_W-1]),
    .b      (b_q),
    .r_next (step_r),
    .sub    (step_sub)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    rv_d    = rv_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          a_d   = A;
          b_d   = B;
          r_d   = '0;
          cnt_d = '0;
          if (B == '0) begin
            state_d = DONE;
            rem_d   = '0;
            dbz_d   = 1'b1;
            rv_d    = 1'b1;
          end else begin
            state_d = RUN;
            dbz_d   = 1'b0;
          end
        end
      end
      RUN: begin
        if (!req) begin
          state_d = IDLE;
        end else begin
          r_d   = step_r;
          // Quotient bits fill the vacated LSBs of the dividend register.
          a_d   = {a_q[DIVIDEND_W-2:0], step_sub};
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
            rem_d   = step_r;
            rv_d    = 1'b1;
          end
        end
      end
      DONE: begin
        if (!req) begin
          state_d = IDLE;
          rv_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      rv_q    <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      rv_q    <= rv_d;
      dbz_q   <= dbz_d;
    end
  end

  assign remainder_valid = rv_q;
  assign remainder       = rem_q;
  assign div_by_zero     = dbz_q;
  assign busy            = (state_q == RUN) || (state_q == DONE);

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Directed bench for mod_reduce_seq with a scoreboard of expected remainders.
module tb_mod_reduce_seq;
  import rsa_pkg::*;

  localparam int DW = RSA_DIVIDEND_W;
  localparam int MW = RSA_MOD_W;
  localparam int LAT = DW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] A;
  logic [MW-1:0] B;
  logic          dividend_valid;
  logic          divisor_valid;
  logic          remainder_valid;
  logic [MW-1:0] remainder;
  logic          div_by_zero;
  logic          busy;

  typedef struct {
    logic [MW-1:0] rem;
    logic          dbz;
    string         tag;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad   = 0;

  mod_reduce_seq dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .A               (A),
    .B               (B),
    .dividend_valid  (dividend_valid),
    .divisor_valid   (divisor_valid),
    .remainder_valid (remainder_valid),
    .remainder       (remainder),
    .div_by_zero     (div_by_zero),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a request on the next negedge; the following posedge is the accept edge.
  task automatic start_op(input logic [DW-1:0] a, input logic [MW-1:0] b, input string tag);
    exp_t e;
    logic [DW-1:0] full;
    @(negedge clk);
    A = a;
    B = b;
    dividend_valid = 1'b1;
    divisor_valid  = 1'b1;
    if (b == '0) begin
      e.rem = '0;
      e.dbz = 1'b1;
    end else begin
      full  = a % {{(DW-MW){1'b0}}, b};
      e.rem = full[MW-1:0];
      e.dbz = 1'b0;
    end
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    // Operands are scrambled after accept; they must be ignored.
    A = {8{32'hdeadbeef}};
    B = 128'd3;
  endtask

  // Called just after the accept edge (cycle 1); waits for remainder_valid and scores it.
  task automatic wait_result(input int exp_cyc, input string tag);
    int cyc;
    exp_t e;
    cyc = 1;
    while (!remainder_valid && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({tag, "_cycle"}, DW'(cyc), DW'(exp_cyc));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_rem"}, DW'(remainder), DW'(e.rem));
      check({tag, "_dbz"}, DW'(div_by_zero), DW'(e.dbz));
    end else begin
      check({tag, "_sb_empty"}, DW'(1), DW'(0));
    end
  endtask

  // Drop both valids from DONE; result valid must fall after that edge, remainder held.
  task automatic release_op(input string tag);
    logic [MW-1:0] held;
    held = remainder;
    @(negedge clk);
    dividend_valid = 1'b0;
    divisor_valid  = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_rv_fall"}, DW'(remainder_valid), DW'(0));
    check({tag, "_busy_fall"}, DW'(busy), DW'(0));
    check({tag, "_rem_hold"}, DW'(remainder), DW'(held));
  endtask

  initial begin
    logic [DW-1:0] nm1;
    rst_n = 1'b0;
    A = '0;
    B = '0;
    dividend_valid = 1'b0;
    divisor_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rv", DW'(remainder_valid), DW'(0));
    check("reset_rem", DW'(remainder), DW'(0));
    check("reset_dbz", DW'(div_by_zero), DW'(0));
    check("reset_busy", DW'(busy), DW'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // 100 mod 7
    start_op(DW'(100), MW'(7), "a100_b7");
    check("a100_b7_busy", DW'(busy), DW'(1));
    check("a100_b7_rv_early", DW'(remainder_valid), DW'(0));
    wait_result(LAT, "a100_b7");
    check("a100_b7_literal", DW'(remainder), DW'(2));
    @(posedge clk);
    #1;
    check("a100_b7_rv_hold", DW'(remainder_valid), DW'(1));
    release_op("a100_b7");

    // all-ones dividend by all-ones modulus
    start_op({DW{1'b1}}, {MW{1'b1}}, "ones");
    wait_result(LAT, "ones");
    check("ones_literal", DW'(remainder), DW'(0));
    release_op("ones");

    // (N-1)^2 mod N
    nm1 = {{(DW-MW){1'b0}}, N_TEST - MW'(1)};
    start_op(nm1 * nm1, N_TEST, "nsq");
    wait_result(LAT, "nsq");
    check("nsq_literal", DW'(remainder), DW'(1));
    release_op("nsq");

    // A < B
    start_op(DW'(5), N_TEST, "small");
    wait_result(LAT, "small");
    check("small_literal", DW'(remainder), DW'(5));
    release_op("small");

    // B == 1 takes the full latency
    start_op(DW'(999), MW'(1), "b1");
    wait_result(LAT, "b1");
    release_op("b1");

    // divide by zero
    start_op(DW'(12345), MW'(0), "bz");
    wait_result(1, "bz");
    check("bz_literal_dbz", DW'(div_by_zero), DW'(1));
    release_op("bz");

    // abort in RUN: drop divisor_valid during cycle 50
    @(negedge clk);
    A = DW'(100);
    B = MW'(7);
    dividend_valid = 1'b1;
    divisor_valid  = 1'b1;
    @(posedge clk);
    repeat (49) @(posedge clk);
    @(negedge clk);
    divisor_valid = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", DW'(busy), DW'(0));
    check("abort_rv", DW'(remainder_valid), DW'(0));
    begin
      int seen;
      seen = 0;
      repeat (300) begin
        @(posedge clk);
        #1;
        if (remainder_valid) seen++;
      end
      check("abort_no_pulse", DW'(seen), DW'(0));
    end
    dividend_valid = 1'b0;
    start_op(DW'(10), MW'(3), "a10_b3");
    wait_result(LAT, "a10_b3");
    check("a10_b3_literal", DW'(remainder), DW'(1));

    // reset at cycle 100 of a run (remainder still holds 1 from last op)
    @(negedge clk);
    dividend_valid = 1'b0;
    divisor_valid  = 1'b0;
    @(negedge clk);
    A = {4{64'h0123456789abcdef}};
    B = N_TEST;
    dividend_valid = 1'b1;
    divisor_valid  = 1'b1;
    @(posedge clk);
    repeat (99) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    dividend_valid = 1'b0;
    divisor_valid  = 1'b0;
    @(posedge clk);
    #1;
    check("rstrun_rv", DW'(remainder_valid), DW'(0));
    check("rstrun_rem", DW'(remainder), DW'(0));
    check("rstrun_busy", DW'(busy), DW'(0));
    check("rstrun_state", DW'(dut.state_q), DW'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // reset while in DONE with div_by_zero set
    start_op(DW'(77), MW'(0), "bz2");
    wait_result(1, "bz2");
    @(negedge clk);
    rst_n = 1'b0;
    dividend_valid = 1'b0;
    divisor_valid  = 1'b0;
    @(posedge clk);
    #1;
    check("rstdone_rv", DW'(remainder_valid), DW'(0));
    check("rstdone_dbz", DW'(div_by_zero), DW'(0));
    check("rstdone_busy", DW'(busy), DW'(0));
    check("rstdone_state", DW'(dut.state_q), DW'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // fresh request after reset
    start_op({4{64'hfedcba9876543210}}, N_TEST, "fresh");
    wait_result(LAT, "fresh");
    release_op("fresh");

    check("sb_drained", DW'(sb.size()), DW'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
